// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
//   Types shared by the packet-stream blocks of the readout path.
//   - DATA_W      : default stream beat width.
//   - arb_state_t : packet arbiter state encoding.
//   - axis_beat_t : one framed stream beat (data + first/last markers).
//                   Also used by other stream blocks.
// ---------------------------------------------------------------------------
package stream_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic              tfirst;
    logic              tlast;
  } axis_beat_t;

endpackage

// File: rtl/stream_pkt_arbiter_if.sv
// ---------------------------------------------------------------------------
// stream_pkt_arbiter_if
//   Bundles the NUM_SRC source streams and the single merged sink stream of
//   the packet arbiter.
//   Source side (per source i):
//     s_tdata[i], s_tfirst[i], s_tlast[i], s_tvalid[i]  -> arbiter
//     s_tready[i]                                       <- arbiter
//   Sink side:
//     m_tdata, m_tfirst, m_tlast, m_tvalid              <- arbiter
//     m_tready                                          -> arbiter
//   Modports:
//     slave  : the arbiter (consumes sources, produces the merged stream)
//     master : the environment (drives sources, sinks the merged stream)
// ---------------------------------------------------------------------------
interface stream_pkt_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64
);

  logic [NUM_SRC-1:0][DATA_W-1:0] s_tdata;
  logic [NUM_SRC-1:0]             s_tfirst;
  logic [NUM_SRC-1:0]             s_tlast;
  logic [NUM_SRC-1:0]             s_tvalid;
  logic [NUM_SRC-1:0]             s_tready;

  logic [DATA_W-1:0]              m_tdata;
  logic                           m_tfirst;
  logic                           m_tlast;
  logic                           m_tvalid;
  logic                           m_tready;

  modport slave (
    input  s_tdata, s_tfirst, s_tlast, s_tvalid,
    output s_tready,
    output m_tdata, m_tfirst, m_tlast, m_tvalid,
    input  m_tready
  );

  modport master (
    output s_tdata, s_tfirst, s_tlast, s_tvalid,
    input  s_tready,
    input  m_tdata, m_tfirst, m_tlast, m_tvalid,
    output m_tready
  );

endinterface

// File: rtl/stream_pkt_arbiter_skid.sv
// ---------------------------------------------------------------------------
// axis_skid_reg
//   Two-entry register slice for axis_beat_t with valid/ready on both sides.
//   Entry 0 is the output register; entry 1 (skid) catches the beat that was
//   accepted in the same cycle the sink stalled. in_ready is a pure register
//   output (not full), so there is no combinational path from out_ready to
//   in_ready.
//   Ports:
//     clk, rst              : clock, asynchronous active-high reset
//     in_beat/in_valid      : upstream beat and valid
//     in_ready              : upstream ready (low only while both entries full)
//     out_beat/out_valid    : registered downstream beat and valid
//     out_ready             : downstream ready
// ---------------------------------------------------------------------------
module axis_skid_reg
  import stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  axis_beat_t in_beat,
  input  logic       in_valid,
  output logic       in_ready,
  output axis_beat_t out_beat,
  output logic       out_valid,
  input  logic       out_ready
);

  axis_beat_t skid_beat;
  logic       skid_valid;
  logic       push;
  logic       pop;

  // The skid entry only ever fills behind a valid output entry, so "full"
  // is exactly skid_valid.
  assign in_ready = ~skid_valid;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset as well because the merged stream
      // must present all-zero data/markers out of reset, not just tvalid = 0.
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else begin
      if (skid_valid) begin
        // Full: upstream is stalled; drain the skid entry into the output.
        if (pop) begin
          out_beat   <= skid_beat;
          skid_valid <= 1'b0;
        end
      end else if (push) begin
        if (!out_valid || pop) begin
          // Output entry free (or freeing this edge): beat goes straight out.
          out_beat  <= in_beat;
          out_valid <= 1'b1;
        end else begin
          // Sink stalled with the output entry occupied: park the beat.
          skid_beat  <= in_beat;
          skid_valid <= 1'b1;
        end
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// stream_pkt_arbiter
//   Packet-level round-robin arbiter merging NUM_SRC framed ADC streams onto
//   one readout FIFO stream. A granted source keeps the output until its
//   tlast beat is accepted, so beats of different packets never interleave.
//   Masked sources (src_ena = 0) are skipped at arbitration time only.
//   Output passes through a 2-entry registered skid stage.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     src_ena      : per-source arbitration enable (sampled in IDLE only)
//     bus          : source streams in, merged stream out (slave modport)
//     grant_valid  : a packet is currently locked
//     grant_id     : locked source index (holds last value while idle)
//     pkt_count    : completed packets forwarded, wrapping at 2^32
// ---------------------------------------------------------------------------
module stream_pkt_arbiter
  import stream_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  parameter  int DATA_W  = stream_pkg::DATA_W,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_ena,
  stream_pkt_arbiter_if.slave  bus,
  output logic                 grant_valid,
  output logic [SRC_W-1:0]     grant_id,
  output logic [31:0]          pkt_count
);

  localparam logic [0:0]     ST_IDLE    = ARB_IDLE;
  localparam logic [0:0]     ST_BUSY    = ARB_BUSY;
  localparam logic [SRC_W:0] NUM_SRC_EW = (SRC_W+1)'(NUM_SRC);

  logic [0:0]         state;
  logic [SRC_W-1:0]   last_grant;
  logic [NUM_SRC-1:0] req;
  logic [SRC_W-1:0]   pick;

  logic [DATA_W-1:0]  sel_tdata;
  axis_beat_t         in_beat;
  logic               in_valid;
  logic               in_ready;
  logic               accept;
  logic               pkt_done;
  axis_beat_t         out_beat;
  logic               out_valid;

  // -------------------------------------------------------------------------
  // Round-robin selection: first requester at or after last_grant+1, with
  // wrap. The loop runs from the farthest offset down to the nearest so the
  // nearest requester is the final (winning) assignment.
  // -------------------------------------------------------------------------
  assign req = bus.s_tvalid & src_ena;

  always_comb begin
    logic [SRC_W:0] pos;
    // NOTE: every variable assigned in combinational logic gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    pick = '0;
    pos  = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      pos = {1'b0, last_grant} + (SRC_W+1)'(k);
      if (pos >= NUM_SRC_EW) begin
        pos = pos - NUM_SRC_EW;
      end
      if (req[pos[SRC_W-1:0]]) begin
        pick = pos[SRC_W-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Input mux: only the granted source reaches the skid stage, and only in
  // BUSY. src_ena is deliberately not consulted here so that disabling the
  // granted source mid-packet cannot truncate the packet.
  // -------------------------------------------------------------------------
  assign sel_tdata = bus.s_tdata[grant_id];
  assign in_valid  = (state == ST_BUSY) & bus.s_tvalid[grant_id];
  assign accept    = in_valid & in_ready;
  // tfirst is carried through untouched; packets are delimited by tlast only.
  assign pkt_done  = accept & bus.s_tlast[grant_id];

  always_comb begin
    in_beat        = '0;
    in_beat.tdata  = sel_tdata;
    in_beat.tfirst = bus.s_tfirst[grant_id];
    in_beat.tlast  = bus.s_tlast[grant_id];
  end

  always_comb begin
    bus.s_tready = '0;
    if (state == ST_BUSY) begin
      bus.s_tready[grant_id] = in_ready;
    end
  end

  assign grant_valid = (state == ST_BUSY);

  // -------------------------------------------------------------------------
  // Grant FSM and packet counter. A tlast accept always returns to IDLE for
  // one cycle; the next grant is decided on the following edge using the
  // freshly updated last_grant (the arbitration bubble).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);  // index 0 wins the first arbitration
      pkt_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant_id <= pick;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (pkt_done) begin
            last_grant <= grant_id;
            pkt_count  <= pkt_count + 32'd1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered output stage toward the FIFO.
  // -------------------------------------------------------------------------
  axis_skid_reg u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_beat   (in_beat),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_beat  (out_beat),
    .out_valid (out_valid),
    .out_ready (bus.m_tready)
  );

  assign bus.m_tdata  = out_beat.tdata;
  assign bus.m_tfirst = out_beat.tfirst;
  assign bus.m_tlast  = out_beat.tlast;
  assign bus.m_tvalid = out_valid;

endmodule

// File: doc/stream_pkt_arbiter.md
# stream_pkt_arbiter

Packet-level round-robin arbiter that merges up to NUM_SRC timestamped ADC packet streams (first/last-framed, 64-bit beats, one per stream subsystem instance) onto the single readout FIFO stream. It never interleaves beats from different packets, and it skips sources that are masked off. It sits between the per-subsystem stream outputs and the DMA/readout FIFO, with a registered output stage toward the FIFO.

## Interface
- NUM_SRC, 4: number of source streams, 2..8.
- DATA_W, 64: beat width.
- SRC_W, $clog2(NUM_SRC): grant index width (derived; not overridden).

Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.

Source and sink streams:
- src_ena  in  NUM_SRC  per-source arbitration enable (quasi-static).
- s_tdata  in  NUM_SRC×DATA_W  source beat data.
- s_tfirst  in  NUM_SRC  first beat of packet.
- s_tlast  in  NUM_SRC  last beat of packet.
- s_tvalid  in  NUM_SRC  source beat valid.
- s_tready  out  NUM_SRC  source beat accepted.
- m_tdata  out  DATA_W  merged beat data.
- m_tfirst  out  1  first beat of packet.
- m_tlast  out  1  last beat of packet.
- m_tvalid  out  1  merged beat valid.
- m_tready  in  1  sink ready.

Status:
- grant_valid  out  1  a packet is currently locked.
- grant_id  out  SRC_W  locked source index.
- pkt_count  out  32  completed packets forwarded, wrapping.

## Operation
- Handshake everywhere: a beat transfers on a clk edge where tvalid and tready are both high. Sources must hold a beat stable while tvalid is high and tready is low.
- Request: req[i] = s_tvalid[i] & src_ena[i].
- State IDLE:
  - s_tready all 0, grant_valid 0.
  - If any req is high, the edge selects the first requesting index searching upward, with wrap, from last_grant+1.
  - It registers that index in grant_id, sets grant_valid, and moves to BUSY.
  - With no request it stays in IDLE.
- State BUSY:
  - s_tready[grant_id] = skid input ready; all other s_tready are 0.
  - Beats pass to the skid stage unchanged: data, tfirst, tlast.
  - An accepted beat with s_tlast = 1 causes: last_grant <= grant_id, pkt_count += 1, go to IDLE.
- src_ena is sampled only in IDLE. Deasserting the granted source's enable in BUSY does not truncate the packet.
- tfirst is not checked; packets are delimited only by tlast.
- A single-beat packet (tfirst = tlast = 1) is legal and completes BUSY in one accepted beat.
- pkt_count wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values:
  - m_tvalid 0, m_tdata 0, m_tfirst 0, m_tlast 0.
  - s_tready 0, grant_valid 0, grant_id 0, pkt_count 0.
  - last_grant = NUM_SRC-1, so index 0 wins first.
- Reset asserted mid-packet: all state clears immediately.
  - The in-flight packet is dropped from the arbiter's view.
  - Source resynchronisation is the sources' responsibility; they share the same reset.
- Latency: a request seen at edge E0 grants at E0. s_tready goes high after E0, the first beat is accepted at E1, and m_tvalid goes high after E1. That is 2 cycles from request to output valid.
- Throughput: 1 beat/clk within a packet while m_tready = 1.
- One IDLE cycle separates consecutive packets: the arbitration bubble.
- Skid stage is 2 entries:
  - input ready = not full;
  - m_tready low with a full buffer stalls the source in the same cycle;
  - no combinational path from m_tready to s_tready.
- Simultaneous events: a tlast accept and a new request in the same cycle resolve as IDLE next cycle, with arbitration on the following edge; the new grant uses the updated last_grant.

## Structure
- Package stream_pkg:
  - DATA_W default;
  - arb_state_t enum {ARB_IDLE, ARB_BUSY};
  - axis_beat_t struct {tdata, tfirst, tlast}. The same struct is used by other stream blocks.
- Sub-module axis_skid_reg:
  - 2-entry register slice on axis_beat_t;
  - valid/ready on both sides;
  - asynchronous active-high reset.
- Top level holds the round-robin selector, grant FSM, input mux and pkt_count.

## Test plan
- Single source: src_ena = 0001, source 0 sends a 5-beat packet (data 1..5) -> m_tvalid 2 cycles after request; m beats 1..5 with tfirst on 1 and tlast on 5; pkt_count = 1; grant_id = 0.
- Fairness: all 4 sources continuously request 3-beat packets -> grant order 0,1,2,3,0,...; one idle cycle between packets; pkt_count = 8 after 8 packets.
- Masking: src_ena = 1010 with all requesting -> only sources 1 and 3 are granted, alternating. Clearing src_ena[1] mid-packet -> that packet completes fully.
- Backpressure: m_tready toggling 1,0,0,1 during an 8-beat packet -> no beat lost or duplicated; s_tready drops the cycle the skid fills; output order is preserved.
- Reset mid-packet: assert rst on beat 3 of 6 -> all outputs 0 immediately. After release, with last_grant = NUM_SRC-1, source 0 is granted first.
- Counter wrap: force pkt_count to 0xFFFF_FFFF and complete one packet -> pkt_count = 0.
